// File: rtl/divmod_pkg.sv
// Shared types and helpers for the sequential divider.
//   state_t   : controller states
//   neg_if    : conditional two's-complement negate, also used as abs()
package divmod_pkg;

  // Widest operand the negate helper supports; callers truncate to their width.
  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Negate x when neg is set. The low W bits of the result are the W-bit
  // two's-complement negation of the low W bits of x, for any W <= MAX_WIDTH.
  function automatic logic [MAX_WIDTH-1:0] neg_if(input logic [MAX_WIDTH-1:0] x,
                                                  input logic                 neg);
    return neg ? (~x + MAX_WIDTH'(1)) : x;
  endfunction

endpackage

// File: rtl/divmod_step.sv
// One radix-2 restoring division step (combinational).
//   rem          : current partial remainder (WIDTH+1 bits)
//   dividend_msb : next dividend bit shifted into the remainder
//   divisor      : divisor magnitude
//   rem_next     : partial remainder after the step
//   q_bit        : quotient bit produced by the step
module divmod_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  // One extra bit above the shifted remainder carries the trial sign.
  logic [WIDTH+1:0] trial;

  always_comb begin
    trial    = {rem, dividend_msb} - {2'b00, divisor};
    q_bit    = ~trial[WIDTH+1];
    rem_next = q_bit ? trial[WIDTH:0] : {rem[WIDTH-1:0], dividend_msb};
  end

endmodule

// File: rtl/divmod_unit.sv
// Sequential integer divider (quotient + remainder), unsigned or signed,
// radix-2 restoring, fixed latency of WIDTH+1 cycles from start.
//   clk, reset       : clock, synchronous active-high reset
//   start, signed_op : request and its operation type
//   a, b             : dividend, divisor (sampled on accepted start)
//   quotient         : result, held until the next accepted start completes
//   remainder        : result, sign follows the dividend
//   busy             : iteration in progress
//   done             : one-cycle pulse when results update
//   div_by_zero      : qualifies the held results
module divmod_unit
  import divmod_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("divmod_unit: WIDTH out of supported range");
  end

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic             q_neg;
  logic             r_neg;

  logic             accept_c;
  logic             last_c;
  logic             b_zero_c;
  logic             sgn_c;
  logic [WIDTH-1:0] abs_a_c;
  logic [WIDTH-1:0] abs_b_c;
  logic [WIDTH:0]   step_rem_c;
  logic             step_q_c;
  logic [WIDTH-1:0] q_raw_c;
  logic [WIDTH-1:0] q_fin_c;
  logic [WIDTH-1:0] r_fin_c;

  // Operand conditioning: magnitudes in signed mode, raw values otherwise.
  always_comb begin
    sgn_c    = SIGNED_EN && signed_op;
    b_zero_c = (b == '0);
    abs_a_c  = WIDTH'(neg_if(MAX_WIDTH'(a), sgn_c && a[WIDTH-1]));
    abs_b_c  = WIDTH'(neg_if(MAX_WIDTH'(b), sgn_c && b[WIDTH-1]));
  end

  divmod_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem          (rem),
    .dividend_msb (dvd[WIDTH-1]),
    .divisor      (dvs),
    .rem_next     (step_rem_c),
    .q_bit        (step_q_c)
  );

  // Final sign fix-up applied to the last step's outputs. MIN / -1 needs no
  // special case: the magnitude quotient is 2^(WIDTH-1) with a positive sign.
  always_comb begin
    q_raw_c = {dvd[WIDTH-2:0], step_q_c};
    q_fin_c = WIDTH'(neg_if(MAX_WIDTH'(q_raw_c), q_neg));
    r_fin_c = WIDTH'(neg_if(MAX_WIDTH'(step_rem_c[WIDTH-1:0]), r_neg));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a start is taken in IDLE or DONE only.
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    last_c     = (count == CNT_W'(WIDTH - 1));
    unique case (state)
      IDLE: begin
        if (start) begin
          accept_c   = 1'b1;
          state_next = b_zero_c ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_c) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
        if (start) begin
          accept_c   = 1'b1;
          state_next = b_zero_c ? DONE : RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      rem         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
      if (accept_c) begin
        dvd   <= abs_a_c;
        dvs   <= abs_b_c;
        rem   <= '0;
        count <= '0;
        q_neg <= sgn_c && (a[WIDTH-1] ^ b[WIDTH-1]);
        r_neg <= sgn_c && a[WIDTH-1];
        // Divide by zero completes immediately with the dividend untouched.
        if (b_zero_c) begin
          quotient    <= '1;
          remainder   <= a;
          div_by_zero <= 1'b1;
        end
      end else if (state == RUN) begin
        rem   <= step_rem_c;
        dvd   <= q_raw_c;
        count <= count + CNT_W'(1);
        if (last_c) begin
          quotient    <= q_fin_c;
          remainder   <= r_fin_c;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/divmod_unit.md
# divmod_unit

Parametrised sequential integer divider returning quotient and remainder for unsigned or signed operands. It uses a radix-2 restoring shift-subtract algorithm, so latency is a fixed WIDTH+1 cycles regardless of operand values. It is the generalised successor to the single-width repeated-subtraction modulo datapath, and serves as the shared div/mod resource behind the ALU's multi-cycle port.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 2)
- SIGNED_EN, 1, when 0 the signed path is removed and `signed_op` is ignored
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted only in IDLE or DONE
- signed_op  input  1  sampled with start; 1 = two's-complement operation
- a  input  WIDTH  dividend, sampled on the accepted start
- b  input  WIDTH  divisor, sampled on the accepted start
- quotient  output  WIDTH  result, valid while `done`=1 and held until the next accepted start
- remainder  output  WIDTH  result, same validity as `quotient`
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse when results become valid
- div_by_zero  output  1  qualifies the result, valid with `done`

## Operation
- States:
  - IDLE → RUN on start with b≠0.
  - IDLE → DONE on start with b=0.
  - RUN → DONE when the step counter reaches WIDTH-1.
  - DONE → IDLE by default.
  - DONE → RUN or DONE when start is high (back-to-back issue).
- On accept:
  - Latch |a| and |b| in signed mode, raw a and b otherwise.
  - Record the quotient sign (a_msb XOR b_msb) and the remainder sign (a_msb).
  - Clear the partial remainder (WIDTH+1 bits) and the counter.
- Each RUN cycle:
  - Shift {rem, dividend} left by 1.
  - trial = rem − divisor.
  - If trial is non-negative, rem = trial and shift in quotient bit 1; otherwise restore rem and shift in 0.
- Entering DONE:
  - Negate the quotient if its sign flag is set; negate the remainder if its sign flag is set.
  - Write `quotient` and `remainder`, and pulse `done`.
- Divide by zero: quotient = all ones, remainder = a unmodified, div_by_zero = 1, no RUN cycles.
- Signed overflow (MIN / −1): quotient = MIN, remainder = 0, div_by_zero = 0. This falls out of the magnitude path and needs no special case.
- Remainder sign follows the dividend (truncating division).
- start while busy is ignored; no queuing, and the operands are not resampled.

## Timing
- Start accepted at edge 0. Normal operation: busy = 1 for edges 1..WIDTH, done = 1 in the cycle after edge WIDTH+1 (latency WIDTH+1). Divide by zero: done at edge 1.
- done is high for exactly one cycle; div_by_zero holds with the results.
- Reset (any state, including mid-RUN) at the next edge forces:
  - state = IDLE
  - busy = 0, done = 0, div_by_zero = 0
  - quotient = 0, remainder = 0, counter = 0
- Reset dominates a simultaneous start.
- start in the DONE cycle is accepted: the new RUN begins the following edge, and the previous results hold until the new done.

## Structure
- Package `divmod_pkg`:
  - state enum {IDLE, RUN, DONE}
  - a helper function for two's-complement negate/abs of a parameter-width value
- Sub-module `divmod_step`: combinational single restoring step.
  - Inputs: rem, dividend msb, divisor.
  - Outputs: next rem, quotient bit.
- Counter width: $clog2(WIDTH).

## Test plan
- Unsigned, WIDTH=32: a=100, b=7, start at cycle 0 → done at cycle 33, quotient=14, remainder=2, div_by_zero=0; busy high for cycles 1–32.
- Signed: a=0xFFFFFFF9 (−7), b=2 → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). Also a=7, b=−2 → quotient=−3, remainder=1.
- Divide by zero: a=5, b=0 → done at cycle 1, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
- Signed overflow: a=0x80000000, b=0xFFFFFFFF → quotient=0x80000000, remainder=0, div_by_zero=0.
- Handshake:
  - A second start at cycle 5 with different operands is ignored; results match the first operation.
  - A start in the done cycle begins a new operation whose done arrives WIDTH+1 cycles later.
- Reset mid-operation: reset at cycle 10 → all outputs 0 and state IDLE at cycle 11; a fresh start (a=9, b=3) gives quotient=3, remainder=0. Repeat at WIDTH=8 with 0xFF/0x10 → quotient=0x0F, remainder=0x0F.
